ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: pc  input  32  address of next instruction, driven by the core's PC register.
REQ-004 SHALL have port: cmd  output  32  fetched instruction to decode.
REQ-005 SHALL have port: cmd_valid  output  1  cmd and fetch_err valid.
REQ-006 SHALL have port: cmd_ready  input  1  core commits this cycle; pc changes on the same edge.
REQ-007 SHALL have port: fetch_err  output  1  fetch faulted (misaligned pc or bus error).
REQ-008 SHALL have port: flush  input  1  invalidate last-fetch buffer (fence.i).
REQ-009 SHALL have port: mem_arvalid  output  1  read address valid.
REQ-010 SHALL have port: mem_araddr  output  32  read address.
REQ-011 SHALL have port: mem_arready  input  1  memory accepts address.
REQ-012 SHALL have port: mem_rvalid  input  1  read data valid.
REQ-013 SHALL have port: mem_rdata  input  32  read data.
REQ-014 SHALL have port: mem_rresp  input  2  0 = OK, nonzero = error.
REQ-015 SHALL have port: mem_rready  output  1  fetch accepts read data.

Function
REQ-016 SHALL implement FSM states IDLE, AR, R, VALID.
REQ-017 IDLE SHALL go to AR on the first edge after reset release.
REQ-018 AR: mem_arvalid=1, mem_araddr=pc, held stable until mem_arready=1, then go to R.
REQ-019 AR with pc[1:0]!=0: no bus request; go to VALID with fetch_err=1 and cmd=32'h00100073 (ebreak).
REQ-020 R: mem_rready=1; on mem_rvalid=1 capture mem_rdata into cmd and go to VALID.
REQ-021 R with mem_rresp!=0 on the capture: fetch_err=1, cmd=32'h00100073.
REQ-022 VALID: cmd_valid=1; cmd and fetch_err held stable until cmd_ready=1, then go to AR.
REQ-023 cmd_ready while cmd_valid=0 SHALL be ignored.
REQ-024 Latency with arready=1 in the AR cycle and rvalid=1 one cycle later: cmd_valid asserts 2 cycles after AR entry.
REQ-025 mem_arvalid and mem_rready SHALL never both be 1.
REQ-026 mem_rvalid outside R SHALL be ignored.
REQ-027 flush SHALL have effect only when IFU_LASTHIT_EN is defined.

Reset
REQ-028 When rst=0, state SHALL become IDLE asynchronously.
REQ-029 When rst=0: cmd=0, cmd_valid=0, fetch_err=0, mem_arvalid=0, mem_araddr=pc, mem_rready=0.
REQ-030 When rst=0, the last-fetch buffer SHALL be invalidated.
REQ-031 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset release SHALL be ignored.

Configuration
REQ-032 Macro IFU_LASTHIT_EN defined: one-entry buffer (last_pc, last_cmd, last_ok) records every error-free bus fetch.
REQ-033 With IFU_LASTHIT_EN, an AR-state hit (pc==last_pc and last_ok=1) SHALL skip the bus (mem_arvalid=0) and reach VALID next cycle with cmd=last_cmd.
REQ-034 With IFU_LASTHIT_EN, flush=1 SHALL clear last_ok on the next edge; flush and capture on the same edge leave last_ok=0.
REQ-035 Without IFU_LASTHIT_EN, no buffer SHALL exist, every fetch uses the bus, and flush is unused.

Verification
REQ-036 Reset release, pc=0x80000000, arready=1, rdata=0x00000413 next cycle -> cmd_valid in cycle 3 with cmd=0x00000413, fetch_err=0.
REQ-037 arready low for 3 cycles in AR -> mem_arvalid=1, mem_araddr=0x80000000 stable all 4 cycles; one request issued.
REQ-038 cmd_ready=0 for 5 cycles in VALID -> cmd unchanged, no new bus request; cmd_ready=1 then AR with new pc=0x80000004.
REQ-039 pc=0x80000002 -> no mem_arvalid; cmd_valid=1, fetch_err=1, cmd=0x00100073. Also: rresp=2 -> same response.
REQ-040 IFU_LASTHIT_EN, jump back to pc=0x80000000 -> no bus request, cmd from buffer next cycle; after flush=1 the same pc issues a bus request.
REQ-041 rst=0 asserted while in R, rvalid arrives after release -> ignored; fetch restarts from IDLE.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Instruction-fetch read bus: one outstanding AR/R transaction at a time.
interface ifu_fetch_if;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;

    // Fetch unit side
    modport master (
        output mem_arvalid, mem_araddr, mem_rready,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rresp
    );

    // Memory side
    modport slave (
        input  mem_arvalid, mem_araddr, mem_rready,
        output mem_arready, mem_rvalid, mem_rdata, mem_rresp
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one instruction per pc, fetched over a simple
// AR/R read bus and held on cmd until the core commits it.
// Optional feature: define IFU_LASTHIT_EN for a one-entry last-fetch buffer
// that serves a repeated pc without a bus access (flush invalidates it).
module ifu_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        fetch_err,
    input  logic        flush,
    ifu_fetch_if.master mem
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        R     = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t          state;
    logic            rready_q;
    logic            misaligned_c;
    logic            hit_c;
    logic [XLEN-1:0] hit_cmd_c;

    assign misaligned_c = (pc[1:0] != 2'b00);

`ifdef IFU_LASTHIT_EN
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] last_cmd;
    logic            last_ok;
    logic [XLEN-1:0] req_pc;

    assign hit_c     = last_ok && (pc == last_pc);
    assign hit_cmd_c = last_cmd;

    // Last-fetch buffer: remember every clean bus fetch; flush wins over capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ok  <= 1'b0;
            last_pc  <= '0;
            last_cmd <= '0;
            req_pc   <= '0;
        end else begin
            if (state == AR && mem.mem_arvalid && mem.mem_arready) begin
                req_pc <= pc;
            end
            if (flush) begin
                last_ok <= 1'b0;
            end else if (state == R && mem.mem_rvalid && mem.mem_rresp == 2'b00) begin
                last_ok  <= 1'b1;
                last_pc  <= req_pc;
                last_cmd <= mem.mem_rdata;
            end
        end
    end
`else
    logic unused_flush;

    assign hit_c        = 1'b0;
    assign hit_cmd_c    = '0;
    assign unused_flush = flush;
`endif

    // Address phase depends on the live pc: the core moves pc on the commit edge
    assign mem.mem_araddr  = pc;
    assign mem.mem_arvalid = (state == AR) && !misaligned_c && !hit_c;
    assign mem.mem_rready  = rready_q;

    // Fetch sequencer: IDLE -> AR -> R -> VALID -> AR ...
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            fetch_err <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= AR;
                end
                AR: begin
                    if (misaligned_c) begin
                        cmd       <= EBREAK;
                        fetch_err <= 1'b1;
                        cmd_valid <= 1'b1;
                        state     <= VALID;
                    end else if (hit_c) begin
                        cmd       <= hit_cmd_c;
                        fetch_err <= 1'b0;
                        cmd_valid <= 1'b1;
                        state     <= VALID;
                    end else if (mem.mem_arready) begin
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (mem.mem_rvalid) begin
                        rready_q  <= 1'b0;
                        cmd_valid <= 1'b1;
                        state     <= VALID;
                        if (mem.mem_rresp != 2'b00) begin
                            cmd       <= EBREAK;
                            fetch_err <= 1'b1;
                        end else begin
                            cmd       <= mem.mem_rdata;
                            fetch_err <= 1'b0;
                        end
                    end
                end
                VALID: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= AR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: scripted scenarios plus randomized fetch sequences
// checked against a transaction-level model of the fetch unit.
module tb_ifu_fetch;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] BASE   = 32'h8000_0000;
`ifdef IFU_LASTHIT_EN
    localparam bit LASTHIT = 1'b1;
`else
    localparam bit LASTHIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h1234_5678;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        fetch_err;
    logic        flush = 1'b0;

    ifu_fetch_if mem_if ();

    ifu_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .fetch_err (fetch_err),
        .flush     (flush),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory responder configuration and state
    int          ar_lat = 0;
    int          r_lat = 0;
    logic [1:0]  resp_cfg = 2'b00;
    int          inject_cnt = 0;
    logic [31:0] cur_addr = '0;
    int          ar_cnt = 0;
    int          r_cnt = 0;

    // bus monitor
    int n_hs = 0;
    int overlap = 0;

    // reference model: one-entry buffer, last expected instruction
    bit          m_ok = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_cmd = '0;
    logic [31:0] g_cmd = '0;
    logic        g_err = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a - BASE) * 32'h9E37_79B1) ^ 32'h0000_0413;
    endfunction

    // Memory: arready after ar_lat wait cycles, rvalid after r_lat wait cycles
    initial begin
        mem_if.mem_arready = 1'b0;
        mem_if.mem_rvalid  = 1'b0;
        mem_if.mem_rdata   = '0;
        mem_if.mem_rresp   = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            if (mem_if.mem_arvalid === 1'b1) begin
                if (ar_cnt >= ar_lat) begin
                    mem_if.mem_arready = 1'b1;
                    cur_addr = mem_if.mem_araddr;
                    ar_cnt = 0;
                end else begin
                    mem_if.mem_arready = 1'b0;
                    ar_cnt++;
                end
            end else begin
                mem_if.mem_arready = 1'b0;
                ar_cnt = 0;
            end
            if (inject_cnt > 0) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = 32'hDEAD_BEEF;
                mem_if.mem_rresp  = 2'b00;
                inject_cnt--;
            end else if (mem_if.mem_rready === 1'b1) begin
                if (r_cnt >= r_lat) begin
                    mem_if.mem_rvalid = 1'b1;
                    mem_if.mem_rdata  = mem_word(cur_addr);
                    mem_if.mem_rresp  = resp_cfg;
                    r_cnt = 0;
                end else begin
                    mem_if.mem_rvalid = 1'b0;
                    r_cnt++;
                end
            end else begin
                mem_if.mem_rvalid = 1'b0;
                r_cnt = 0;
            end
        end
    end

    // Count address handshakes and arvalid/rready overlaps
    initial begin
        forever begin
            @(negedge clk);
            if (mem_if.mem_arvalid === 1'b1 && mem_if.mem_arready === 1'b1) n_hs++;
            if (mem_if.mem_arvalid === 1'b1 && mem_if.mem_rready === 1'b1) overlap++;
        end
    end

    task automatic model_reset();
        m_ok = 1'b0;
    endtask

    task automatic model_flush();
        if (LASTHIT) m_ok = 1'b0;
    endtask

    // Expected result of fetching p: instruction, error flag, bus requests, cycles
    task automatic model_fetch(input logic [31:0] p, input logic [1:0] rs,
                               input int arl, input int rl,
                               output int ereq, output int ecyc);
        if (p[1:0] != 2'b00) begin
            g_cmd = EBREAK; g_err = 1'b1; ereq = 0; ecyc = 1;
        end else if (LASTHIT && m_ok && m_pc == p) begin
            g_cmd = m_cmd; g_err = 1'b0; ereq = 0; ecyc = 1;
        end else begin
            ereq = 1;
            ecyc = arl + rl + 2;
            if (rs != 2'b00) begin
                g_cmd = EBREAK; g_err = 1'b1;
            end else begin
                g_cmd = mem_word(p); g_err = 1'b0;
                if (LASTHIT) begin
                    m_ok = 1'b1; m_pc = p; m_cmd = g_cmd;
                end
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) ok = 1'b1;
            else cyc++;
        end
    endtask

    // Called at a negedge while cmd_valid is high: commit and present pc p
    task automatic commit_to(input logic [31:0] p);
        pc = p;
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid got=%b want=0", cmd_valid); end
        total++; if (cmd !== 32'h0) begin bad++; $display("FAIL rst_cmd got=%h want=0", cmd); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", fetch_err); end
        total++; if (mem_if.mem_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", mem_if.mem_arvalid); end
        total++; if (mem_if.mem_rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", mem_if.mem_rready); end
        total++; if (mem_if.mem_araddr !== 32'h1234_5678) begin bad++; $display("FAIL rst_araddr got=%h want=12345678", mem_if.mem_araddr); end
        repeat (2) @(negedge clk);
        total++; if (cmd_valid !== 1'b0 || mem_if.mem_arvalid !== 1'b0) begin bad++; $display("FAIL rst_held valid=%b arvalid=%b want=0/0", cmd_valid, mem_if.mem_arvalid); end
    endtask

    task automatic test_first_fetch();
        int ereq, ecyc, cyc, h0;
        bit ok;
        ar_lat = 0; r_lat = 0; resp_cfg = 2'b00;
        model_reset();
        pc = BASE;
        @(posedge clk);
        #1;
        rst = 1'b1;
        h0 = n_hs;
        model_fetch(BASE, 2'b00, 0, 0, ereq, ecyc);
        wait_valid(50, ok, cyc);
        total++; if (!ok) begin bad++; $display("FAIL first_timeout got=no_valid want=valid"); end
        total++; if (cyc !== 3) begin bad++; $display("FAIL first_latency got=%0d want=3", cyc); end
        total++; if (cmd !== 32'h0000_0413 || fetch_err !== 1'b0) begin bad++; $display("FAIL first_cmd got=%h/%b want=00000413/0", cmd, fetch_err); end
        total++; if (n_hs - h0 !== ereq) begin bad++; $display("FAIL first_reqs got=%0d want=%0d", n_hs - h0, ereq); end
    endtask

    task automatic test_ar_stall();
        int ereq, ecyc, cyc, h0;
        bit ok;
        rst = 1'b0;
        ar_lat = 3; r_lat = 0; resp_cfg = 2'b00;
        model_reset();
        pc = BASE;
        @(posedge clk);
        #1;
        rst = 1'b1;
        h0 = n_hs;
        model_fetch(BASE, 2'b00, 3, 0, ereq, ecyc);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (mem_if.mem_arvalid !== 1'b1 || mem_if.mem_araddr !== BASE) begin
                bad++;
                $display("FAIL ar_stall_hold cyc=%0d got=%b/%h want=1/%h", i, mem_if.mem_arvalid, mem_if.mem_araddr, BASE);
            end
        end
        wait_valid(50, ok, cyc);
        ar_lat = 0;
        total++; if (!ok || cmd !== g_cmd) begin bad++; $display("FAIL ar_stall_cmd got=%h want=%h", cmd, g_cmd); end
        total++; if (n_hs - h0 !== 1) begin bad++; $display("FAIL ar_stall_reqs got=%0d want=1", n_hs - h0); end
    endtask

    task automatic test_hold();
        int ereq, ecyc, cyc, h0;
        bit ok;
        h0 = n_hs;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (cmd !== g_cmd || cmd_valid !== 1'b1 || mem_if.mem_arvalid !== 1'b0) begin
                bad++;
                $display("FAIL hold cyc=%0d got=%h/%b/%b want=%h/1/0", i, cmd, cmd_valid, mem_if.mem_arvalid, g_cmd);
            end
        end
        total++; if (n_hs !== h0) begin bad++; $display("FAIL hold_reqs got=%0d want=0", n_hs - h0); end
        ar_lat = 1;
        commit_to(BASE + 32'd4);
        model_fetch(BASE + 32'd4, 2'b00, 1, 0, ereq, ecyc);
        @(negedge clk);
        total++; if (mem_if.mem_arvalid !== 1'b1 || mem_if.mem_araddr !== 32'h8000_0004) begin bad++; $display("FAIL hold_next_ar got=%b/%h want=1/80000004", mem_if.mem_arvalid, mem_if.mem_araddr); end
        wait_valid(50, ok, cyc);
        ar_lat = 0;
        total++; if (!ok || cmd !== g_cmd || fetch_err !== 1'b0) begin bad++; $display("FAIL hold_next_cmd got=%h/%b want=%h/0", cmd, fetch_err, g_cmd); end
    endtask

    task automatic test_errors();
        int ereq, ecyc, cyc, h0;
        bit ok;
        h0 = n_hs;
        commit_to(BASE + 32'd2);
        model_fetch(BASE + 32'd2, 2'b00, 0, 0, ereq, ecyc);
        wait_valid(50, ok, cyc);
        total++; if (!ok || cmd !== EBREAK || fetch_err !== 1'b1) begin bad++; $display("FAIL misaligned got=%h/%b want=%h/1", cmd, fetch_err, EBREAK); end
        total++; if (cyc !== 1 || n_hs !== h0) begin bad++; $display("FAIL misaligned_bus got=cyc%0d/req%0d want=cyc1/req0", cyc, n_hs - h0); end
        resp_cfg = 2'd2;
        h0 = n_hs;
        commit_to(BASE + 32'h10);
        model_fetch(BASE + 32'h10, 2'd2, 0, 0, ereq, ecyc);
        wait_valid(50, ok, cyc);
        resp_cfg = 2'b00;
        total++; if (!ok || cmd !== EBREAK || fetch_err !== 1'b1) begin bad++; $display("FAIL rresp_err got=%h/%b want=%h/1", cmd, fetch_err, EBREAK); end
        total++; if (n_hs - h0 !== 1) begin bad++; $display("FAIL rresp_reqs got=%0d want=1", n_hs - h0); end
    endtask

    task automatic test_reset_mid();
        int ereq, ecyc, cyc, h0;
        bit ok;
        bit in_r;
        r_lat = 20;
        commit_to(BASE + 32'h20);
        in_r = 1'b0;
        for (int i = 0; i < 10 && !in_r; i++) begin
            @(negedge clk);
            if (mem_if.mem_rready === 1'b1) in_r = 1'b1;
        end
        total++; if (!in_r) begin bad++; $display("FAIL rmid_reach_r got=0 want=1"); end
        rst = 1'b0;
        #1;
        total++; if (cmd_valid !== 1'b0 || mem_if.mem_rready !== 1'b0 || cmd !== 32'h0) begin bad++; $display("FAIL rmid_async got=%b/%b/%h want=0/0/0", cmd_valid, mem_if.mem_rready, cmd); end
        model_reset();
        r_lat = 0;
        @(posedge clk);
        #1;
        inject_cnt = 2;
        rst = 1'b1;
        h0 = n_hs;
        model_fetch(BASE + 32'h20, 2'b00, 0, 0, ereq, ecyc);
        wait_valid(50, ok, cyc);
        total++; if (!ok || cmd !== g_cmd || fetch_err !== 1'b0) begin bad++; $display("FAIL rmid_cmd got=%h/%b want=%h/0", cmd, fetch_err, g_cmd); end
        total++; if (cyc !== 3 || n_hs - h0 !== 1) begin bad++; $display("FAIL rmid_restart got=cyc%0d/req%0d want=cyc3/req1", cyc, n_hs - h0); end
    endtask

    task automatic test_lasthit();
        logic [31:0] seq [4];
        int ereq, ecyc, cyc, h0;
        bit ok;
        seq[0] = BASE; seq[1] = BASE + 32'd4; seq[2] = BASE; seq[3] = BASE;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                @(negedge clk);
                model_flush();
            end
            h0 = n_hs;
            commit_to(seq[i]);
            model_fetch(seq[i], 2'b00, 0, 0, ereq, ecyc);
            wait_valid(50, ok, cyc);
            total++;
            if (!ok || cmd !== g_cmd || fetch_err !== 1'b0 || cyc !== ecyc || n_hs - h0 !== ereq) begin
                bad++;
                $display("FAIL lasthit step=%0d got=%h/%b/cyc%0d/req%0d want=%h/0/cyc%0d/req%0d", i, cmd, fetch_err, cyc, n_hs - h0, g_cmd, ecyc, ereq);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] p;
        logic [31:0] last_al;
        logic [1:0]  rs;
        int ereq, ecyc, cyc, h0, sel, al, rl;
        bit ok;
        last_al = BASE;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) p = BASE + {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (sel <= 3) p = last_al;
            else p = BASE + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (p[1:0] == 2'b00) last_al = p;
            al = int'($urandom_range(0, 3));
            rl = int'($urandom_range(0, 3));
            rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 4) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                @(negedge clk);
                model_flush();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ar_lat = al; r_lat = rl; resp_cfg = rs;
            h0 = n_hs;
            commit_to(p);
            model_fetch(p, rs, al, rl, ereq, ecyc);
            wait_valid(50, ok, cyc);
            total++;
            if (!ok || cmd !== g_cmd || fetch_err !== g_err) begin
                bad++;
                $display("FAIL rand_cmd n=%0d pc=%h got=%h/%b want=%h/%b", n, p, cmd, fetch_err, g_cmd, g_err);
            end
            total++;
            if (cyc !== ecyc || n_hs - h0 !== ereq) begin
                bad++;
                $display("FAIL rand_timing n=%0d pc=%h got=cyc%0d/req%0d want=cyc%0d/req%0d", n, p, cyc, n_hs - h0, ecyc, ereq);
            end
        end
        ar_lat = 0; r_lat = 0; resp_cfg = 2'b00;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_ar_stall();
        test_hold();
        test_errors();
        test_reset_mid();
        test_lasthit();
        test_random();
        total++; if (overlap !== 0) begin bad++; $display("FAIL arvalid_rready_overlap got=%0d want=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
